// File: rtl/lane_elastic_pipe.sv
// Multi-lane valid/ready register stage with DEPTH entries of elastic buffering.
// Define LANE_PIPE_IDLE_ZERO_EN to force out_data to zero while out_valid is low.
module lane_elastic_pipe #(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic                   clkf,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [LW-1:0]          level,
    output logic                   overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned DW = LANES * WIDTH;

    localparam logic [LW-1:0] CntFull = LW'(DEPTH);
    localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    // Flow control is a function of state only; out_ready never reaches in_ready.
    assign in_ready  = (cnt_q != CntFull);
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign level     = cnt_q;
    assign overflow  = overflow_q;

`ifdef LANE_PIPE_IDLE_ZERO_EN
    assign out_data = out_valid ? mem_q[rp_q] : '0;
`else
    assign out_data = mem_q[rp_q];
`endif

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (in_valid & ~in_ready);
        if (push) begin
            wp_d = (wp_q == PtrLast) ? '0 : wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = (rp_q == PtrLast) ? '0 : rp_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clkf) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; contents are only observable once written.
    always_ff @(posedge clkf) begin
        if (push && !reset) begin
            mem_q[wp_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_lane_elastic_pipe.sv
// Directed bench for lane_elastic_pipe with a queue scoreboard as the reference model.
module tb_lane_elastic_pipe;

    localparam int DEPTH = 4;

    logic        clkf;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q[$];
    logic        ovf_m = 1'b0;

    lane_elastic_pipe dut (
        .clkf      (clkf),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    initial begin
        clkf = 1'b0;
        forever #5 clkf = ~clkf;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model, then advance model and DUT by one edge.
    task automatic cycle(input bit chk);
        logic push_m, pop_m;
        push_m = in_valid && (q.size() != DEPTH);
        pop_m  = out_ready && (q.size() != 0);
        if (chk) begin
            check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("level", 64'(level), 64'(q.size()));
            check("overflow", 64'(overflow), 64'(ovf_m));
            if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
`ifdef LANE_PIPE_IDLE_ZERO_EN
            else check("idle_zero", 64'(out_data), 64'd0);
`endif
        end
        if (in_valid && q.size() == DEPTH) ovf_m = 1'b1;
        @(posedge clkf);
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(in_data);
        if (reset) begin
            q.delete();
            ovf_m = 1'b0;
        end
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset for two cycles, then check idle state and one-cycle latency.
        cycle(1'b0);
        cycle(1'b0);
        reset = 1'b0;
        cycle(1'b1);
        in_valid = 1'b1;
        in_data  = 32'hA3B2C1D0;
        cycle(1'b1);
        in_valid = 1'b0;
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_data", 64'(out_data), 64'hA3B2C1D0);
        cycle(1'b1);
        out_ready = 1'b1;
        cycle(1'b1);
        out_ready = 1'b0;

        // Fill past full with a stalled consumer, then drain.
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = {4{8'(i)}};
            cycle(1'b1);
        end
        in_valid = 1'b0;
        check("full_level", 64'(level), 64'd4);
        check("full_ovf", 64'(overflow), 64'd1);
        cycle(1'b1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 64'(out_data), 64'({4{8'(i)}}));
            cycle(1'b1);
        end
        check("drained", 64'(out_valid), 64'd0);
        cycle(1'b1);

        // Sustained streaming at one beat per cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'h1000_0000 + 32'(i);
            cycle(1'b1);
            check("stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cycle(1'b1);

        // Simultaneous push/pop at level 2.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE0001;
        cycle(1'b1);
        in_data   = 32'hCAFE0002;
        cycle(1'b1);
        out_ready = 1'b1;
        in_data   = 32'hCAFE0003;
        cycle(1'b1);
        check("pp_level", 64'(level), 64'd2);
        check("pp_head", 64'(out_data), 64'hCAFE0002);

        // Bring to full, then pop with a push offered while full.
        out_ready = 1'b0;
        in_data   = 32'hCAFE0004;
        cycle(1'b1);
        in_data   = 32'hCAFE0005;
        cycle(1'b1);
        out_ready = 1'b1;
        in_data   = 32'hCAFE0006;
        cycle(1'b1);
        check("fullpop_level", 64'(level), 64'd3);
        check("fullpop_ready", 64'(in_ready), 64'd1);

        // Reset at level 3 while a push is offered.
        out_ready = 1'b0;
        reset     = 1'b1;
        cycle(1'b1);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        cycle(1'b1);
        in_valid = 1'b1;
        in_data  = 32'h5A5A5A5A;
        cycle(1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
